mem_copy_dma: RTL and testbench
===============================

Name: mem_copy_dma

Overview:
- Bus initiator that copies a block of 32-bit words from a source address to a destination address.
- Drives the same native memory request interface the CPU uses: valid/addr/wdata/wstrb out, ready/rdata in. It is the requesting end of that protocol; the address-decoded cores are the responding end.
- Configured by firmware through a standard MMIO core port (cs/we/address/write_data/read_data/ready).
- Arbitration with the CPU happens outside this block.

Parameters:
- TIMEOUT_CYCLES, 16'd1024: maximum cycles one outstanding transaction may wait for mem_ready. Used only with the optional feature.

Ports:
- clk  in  1  clock
- reset_n  in  1  synchronous, active-low reset
- cs  in  1  config port select
- we  in  1  config write enable
- address  in  8  config word address
- write_data  in  32  config write data
- read_data  out  32  config read data
- ready  out  1  config access done
- mem_valid  out  1  initiator request valid
- mem_addr  out  32  request address, word aligned
- mem_wdata  out  32  write data
- mem_wstrb  out  4  byte strobes; 0 = read, 4'hf = write
- mem_ready  in  1  responder done, one-cycle pulse
- mem_rdata  in  32  read data, valid with mem_ready
- done_irq  out  1  one-cycle pulse on completion, abort or error

Behaviour:
- Reset: all outputs 0; state IDLE; SRC, DST, LEN, REMAINING = 0; status bits cleared.
- Config registers (word address):
  - 0x00 NAME0 = "dma_" (RO)
  - 0x01 NAME1 = "copy" (RO)
  - 0x02 VERSION = 32'h1 (RO)
  - 0x08 CTRL (WO): bit0 start, bit1 abort
  - 0x09 STATUS (RO): bit0 busy, bit1 done, bit2 aborted, bit3 timeout
  - 0x10 SRC, 0x11 DST (RW): bits[1:0] forced to 0 on write
  - 0x12 LEN (RW): length in words, 16 bits, upper bits read 0
  - 0x13 REMAINING (RO)
  - Any other address reads 0; writes to it are ignored.
- Config port timing: ready = cs, combinational, zero wait. read_data is combinational from address and is 0 when cs is low.
- Writes to SRC, DST or LEN while busy are ignored. A start while busy is ignored.
- Start when idle:
  - Clears done, aborted and timeout.
  - Loads the working address/count registers from SRC, DST and LEN.
  - LEN = 0: sets done and pulses done_irq the next cycle; no bus traffic.
- FSM states: IDLE -> RD -> RD_GAP -> WR -> WR_GAP -> RD ... -> IDLE.
  - RD: mem_valid=1, mem_wstrb=0, mem_addr=src. On mem_ready, capture mem_rdata into the data register, drop mem_valid the next cycle, go to RD_GAP.
  - WR: mem_valid=1, mem_wstrb=4'hf, mem_addr=dst, mem_wdata=data register. On mem_ready: src+=4, dst+=4, REMAINING-=1, go to WR_GAP.
  - Each GAP state holds mem_valid low for exactly one cycle. This is mandatory, because the responder side registers ready and qualifies requests with !ready.
  - WR_GAP goes to IDLE if REMAINING == 0, else to RD.
  - Entering IDLE from a copy: set done, pulse done_irq.
- Protocol rules:
  - mem_addr, mem_wdata and mem_wstrb are registered and stable while mem_valid=1.
  - mem_valid never drops before mem_ready, except on timeout.
- Arithmetic: addresses wrap mod 2^32, no error on wrap. REMAINING is 16 bits.
- Abort:
  - Sets a pending flag.
  - The outstanding transaction still completes; the FSM then goes to IDLE from the next GAP state.
  - Sets aborted, not done; pulses done_irq.
  - Abort while idle: no effect.
- Start and abort in the same write: abort wins if busy; start wins if idle.
- Reset mid-copy: immediate return to reset values; mem_valid low in the cycle after reset is sampled.

Optional Feature:
- Macro: MEM_COPY_DMA_TIMEOUT_EN
- With the macro defined:
  - A 16-bit wait counter counts cycles of mem_valid=1 without mem_ready.
  - When the counter reaches TIMEOUT_CYCLES: drop mem_valid, set timeout, go to IDLE, pulse done_irq.
  - The counter clears at each new request.
- Without the macro: no counter; STATUS bit3 reads 0; the block waits indefinitely.

Decomposition:
- Shared include header holds: register address constants, CTRL/STATUS bit positions, FSM state encodings, NAME/VERSION constants.
- Single module, no sub-module. A config-register sub-module is not warranted at this size.

Test Plan:
- SRC=0x40000000, DST=0x40001000, LEN=4, responder ready latency 1:
  - bus shows 8 transactions alternating RD/WR with addresses incrementing by 4;
  - DST words equal SRC words;
  - done=1, one done_irq pulse;
  - mem_valid low for at least one cycle between each transaction.
- LEN=0, start -> no mem_valid ever; done set the next cycle.
- Random responder latency 1-7 cycles -> mem_addr/wdata/wstrb stable throughout each valid; data intact.
- Abort written during RD of word 2 of 8 -> that read finishes, no further write; aborted=1, done=0, REMAINING=6.
- SRC=0xFFFFFFF8, LEN=3 -> reads at 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000.
- With MEM_COPY_DMA_TIMEOUT_EN and TIMEOUT_CYCLES=16, responder never readies -> mem_valid drops after 16 cycles; timeout=1; done_irq pulses.

Source files
------------

// File: rtl/mem_copy_dma_pkg.sv
// Shared constants for mem_copy_dma: config register map, CTRL/STATUS bit
// positions, identification words and FSM state encodings.
package mem_copy_dma_pkg;

  localparam logic [7:0] ADDR_NAME0     = 8'h00;
  localparam logic [7:0] ADDR_NAME1     = 8'h01;
  localparam logic [7:0] ADDR_VERSION   = 8'h02;
  localparam logic [7:0] ADDR_CTRL      = 8'h08;
  localparam logic [7:0] ADDR_STATUS    = 8'h09;
  localparam logic [7:0] ADDR_SRC       = 8'h10;
  localparam logic [7:0] ADDR_DST       = 8'h11;
  localparam logic [7:0] ADDR_LEN       = 8'h12;
  localparam logic [7:0] ADDR_REMAINING = 8'h13;

  localparam int CTRL_START   = 0;
  localparam int CTRL_ABORT   = 1;
  localparam int STAT_BUSY    = 0;
  localparam int STAT_DONE    = 1;
  localparam int STAT_ABORTED = 2;
  localparam int STAT_TIMEOUT = 3;

  // ASCII "dma_" and "copy"
  localparam logic [31:0] NAME0_VAL   = 32'h646d_615f;
  localparam logic [31:0] NAME1_VAL   = 32'h636f_7079;
  localparam logic [31:0] VERSION_VAL = 32'h0000_0001;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RD     = 3'd1,
    ST_RD_GAP = 3'd2,
    ST_WR     = 3'd3,
    ST_WR_GAP = 3'd4
  } state_t;

endpackage

// File: rtl/mem_copy_dma.sv
// Word-copy DMA initiator on the native memory request bus, configured over MMIO.
// Optional per-transaction wait timeout enabled by defining MEM_COPY_DMA_TIMEOUT_EN.
//
// state     | meaning
// ----------+-------------------------------------------------------
// ST_IDLE   | no copy in progress, bus idle
// ST_RD     | read request to src outstanding
// ST_RD_GAP | one idle bus cycle after the read completes
// ST_WR     | write request to dst outstanding
// ST_WR_GAP | one idle bus cycle after the write completes
module mem_copy_dma
  import mem_copy_dma_pkg::*;
#(
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd1024
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cs,
  input  logic        we,
  input  logic [7:0]  address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  output logic        mem_valid,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        done_irq
);

  state_t      r_state, w_state_nxt;
  logic [31:0] r_src, r_dst, r_cur_src, r_cur_dst, r_data;
  logic [15:0] r_len, r_remaining;
  logic        r_done, r_aborted, r_timeout, r_abort_pend, r_irq;
  logic        r_mem_valid;
  logic [31:0] r_mem_addr, r_mem_wdata;
  logic [3:0]  r_mem_wstrb;

  logic w_busy, w_cfg_wr, w_ctrl_wr, w_start, w_abort, w_stop, w_finish, w_timeout;
  logic w_in_req;

  assign w_busy    = (r_state != ST_IDLE);
  assign w_in_req  = (r_state == ST_RD) || (r_state == ST_WR);
  assign w_cfg_wr  = cs && we;
  assign w_ctrl_wr = w_cfg_wr && (address == ADDR_CTRL);
  assign w_start   = w_ctrl_wr && write_data[CTRL_START] && !w_busy;
  assign w_abort   = w_ctrl_wr && write_data[CTRL_ABORT] && w_busy;
  // an abort arriving during a gap cycle stops the copy right there
  assign w_stop    = r_abort_pend || w_abort;
  assign w_finish  = w_busy && (w_state_nxt == ST_IDLE);

`ifdef MEM_COPY_DMA_TIMEOUT_EN
  logic [15:0] r_wait_cnt;

  assign w_timeout = w_in_req && !mem_ready && (r_wait_cnt == TIMEOUT_CYCLES - 16'd1);

  always_ff @(posedge clk) begin
    if (!reset_n)                             r_wait_cnt <= '0;
    else if (w_in_req && !mem_ready && !w_timeout) r_wait_cnt <= r_wait_cnt + 16'd1;
    else                                      r_wait_cnt <= '0;
  end
`else
  logic w_unused_tmo;

  assign w_timeout    = 1'b0;
  assign w_unused_tmo = ^TIMEOUT_CYCLES;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (w_start && (r_len != 16'd0)) w_state_nxt = ST_RD;
      ST_RD:     if (mem_ready) w_state_nxt = ST_RD_GAP;
                 else if (w_timeout) w_state_nxt = ST_IDLE;
      ST_RD_GAP: w_state_nxt = w_stop ? ST_IDLE : ST_WR;
      ST_WR:     if (mem_ready) w_state_nxt = ST_WR_GAP;
                 else if (w_timeout) w_state_nxt = ST_IDLE;
      ST_WR_GAP: w_state_nxt = (w_stop || (r_remaining == 16'd0)) ? ST_IDLE : ST_RD;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_src        <= '0;
      r_dst        <= '0;
      r_len        <= '0;
      r_remaining  <= '0;
      r_cur_src    <= '0;
      r_cur_dst    <= '0;
      r_data       <= '0;
      r_done       <= 1'b0;
      r_aborted    <= 1'b0;
      r_timeout    <= 1'b0;
      r_abort_pend <= 1'b0;
      r_irq        <= 1'b0;
      r_mem_valid  <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_mem_wstrb  <= '0;
    end else begin
      r_irq <= 1'b0;
      if (w_cfg_wr && !w_busy) begin
        if (address == ADDR_SRC) r_src <= {write_data[31:2], 2'b00};
        if (address == ADDR_DST) r_dst <= {write_data[31:2], 2'b00};
        if (address == ADDR_LEN) r_len <= write_data[15:0];
      end
      if (w_abort) r_abort_pend <= 1'b1;

      if (w_start) begin
        r_done       <= (r_len == 16'd0);
        r_irq        <= (r_len == 16'd0);
        r_aborted    <= 1'b0;
        r_timeout    <= 1'b0;
        r_abort_pend <= 1'b0;
        r_cur_src    <= r_src;
        r_cur_dst    <= r_dst;
        r_remaining  <= r_len;
        if (r_len != 16'd0) begin
          r_mem_valid <= 1'b1;
          r_mem_addr  <= r_src;
          r_mem_wstrb <= 4'h0;
        end
      end

      case (r_state)
        ST_RD: if (mem_ready) begin
          r_data      <= mem_rdata;
          r_mem_valid <= 1'b0;
        end
        ST_RD_GAP: if (!w_stop) begin
          r_mem_valid <= 1'b1;
          r_mem_addr  <= r_cur_dst;
          r_mem_wdata <= r_data;
          r_mem_wstrb <= 4'hf;
        end
        ST_WR: if (mem_ready) begin
          r_mem_valid <= 1'b0;
          r_cur_src   <= r_cur_src + 32'd4;
          r_cur_dst   <= r_cur_dst + 32'd4;
          r_remaining <= r_remaining - 16'd1;
        end
        ST_WR_GAP: if (w_state_nxt == ST_RD) begin
          r_mem_valid <= 1'b1;
          r_mem_addr  <= r_cur_src;
          r_mem_wstrb <= 4'h0;
        end
        default: ;
      endcase

      if (w_timeout) r_mem_valid <= 1'b0;

      if (w_finish) begin
        r_irq        <= 1'b1;
        r_abort_pend <= 1'b0;
        if (w_timeout)   r_timeout <= 1'b1;
        else if (w_stop) r_aborted <= 1'b1;
        else             r_done    <= 1'b1;
      end
    end
  end

  always_comb begin
    read_data = '0;
    if (cs) begin
      case (address)
        ADDR_NAME0:     read_data = NAME0_VAL;
        ADDR_NAME1:     read_data = NAME1_VAL;
        ADDR_VERSION:   read_data = VERSION_VAL;
        ADDR_STATUS: begin
          read_data[STAT_BUSY]    = w_busy;
          read_data[STAT_DONE]    = r_done;
          read_data[STAT_ABORTED] = r_aborted;
          read_data[STAT_TIMEOUT] = r_timeout;
        end
        ADDR_SRC:       read_data = r_src;
        ADDR_DST:       read_data = r_dst;
        ADDR_LEN:       read_data = {16'h0, r_len};
        ADDR_REMAINING: read_data = {16'h0, r_remaining};
        default:        read_data = '0;
      endcase
    end
  end

  assign ready     = cs;
  assign mem_valid = r_mem_valid;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_wstrb = r_mem_wstrb;
  assign done_irq  = r_irq;

endmodule

// File: tb/tb_mem_copy_dma.sv
// Self-checking bench for mem_copy_dma: memory responder model, bus monitor and
// transaction scoreboard; the timeout scenario runs when MEM_COPY_DMA_TIMEOUT_EN is defined.
module tb_mem_copy_dma;
  import mem_copy_dma_pkg::*;

  typedef struct packed {
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] data;
  } txn_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cs = 1'b0, we = 1'b0;
  logic [7:0]  address = '0;
  logic [31:0] write_data = '0;
  logic [31:0] read_data;
  logic        ready;
  logic        mem_valid;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        done_irq;

  int total = 0;
  int bad = 0;

  logic [31:0] mem [logic [31:0]];
  txn_t exp_q[$];
  txn_t obs_q[$];

  // responder knobs, written only by the stimulus process
  logic rsp_en = 1'b1;
  logic rsp_rand = 1'b0;
  int   rsp_fixed_lat = 1;

  // monitor counters, written only by the monitor
  int irq_cnt = 0, irq_wide = 0, gap_viol = 0, unstable = 0, valid_cycles = 0;

  mem_copy_dma #(.TIMEOUT_CYCLES(16'd16)) dut (
    .clk(clk), .reset_n(reset_n), .cs(cs), .we(we), .address(address),
    .write_data(write_data), .read_data(read_data), .ready(ready),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .done_irq(done_irq)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] pat(input logic [31:0] a);
    return (a ^ 32'h5a5a_c3c3) + {a[15:0], a[31:16]};
  endfunction

  // responder: registered ready, qualifies requests with !ready
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata = '0;
  int          rsp_cnt = 0, rsp_cur_lat = 1;
  assign mem_ready = rsp_ready;
  assign mem_rdata = rsp_rdata;

  always @(posedge clk) begin
    int lat_now;
    if (!reset_n) begin
      rsp_ready <= 1'b0;
      rsp_cnt   <= 0;
    end else if (rsp_ready) begin
      rsp_ready <= 1'b0;
    end else if (mem_valid && rsp_en) begin
      lat_now = (rsp_cnt == 0) ? (rsp_rand ? int'($urandom_range(1, 7)) : rsp_fixed_lat) : rsp_cur_lat;
      rsp_cur_lat <= lat_now;
      if (rsp_cnt + 1 >= lat_now) begin
        rsp_ready <= 1'b1;
        rsp_cnt   <= 0;
        if (mem_wstrb == 4'hf) mem[mem_addr] = mem_wdata;
        else rsp_rdata <= mem.exists(mem_addr) ? mem[mem_addr] : 32'hdead_beef;
      end else begin
        rsp_cnt <= rsp_cnt + 1;
      end
    end
  end

  // bus monitor
  logic        p_valid = 1'b0, p_ready = 1'b0, p_irq = 1'b0;
  logic [67:0] p_bus = '0;
  always @(negedge clk) begin
    if (reset_n) begin
      if (mem_valid && mem_ready)
        obs_q.push_back('{mem_wstrb, mem_addr, (mem_wstrb == 4'hf) ? mem_wdata : mem_rdata});
      if (mem_valid && p_valid && !p_ready && ({mem_addr, mem_wdata, mem_wstrb} != p_bus))
        unstable++;
      if (mem_valid && p_ready) gap_viol++;
      if (mem_valid) valid_cycles++;
      if (done_irq) irq_cnt++;
      if (done_irq && p_irq) irq_wide++;
    end
    p_valid = mem_valid;
    p_ready = mem_ready;
    p_irq   = done_irq;
    p_bus   = {mem_addr, mem_wdata, mem_wstrb};
  end

  task automatic cfg_write(input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    cs = 1'b1; we = 1'b1; address = a; write_data = d;
    @(negedge clk);
    cs = 1'b0; we = 1'b0;
  endtask

  task automatic cfg_read(input logic [7:0] a, output logic [31:0] d);
    @(negedge clk);
    cs = 1'b1; we = 1'b0; address = a;
    #1 d = read_data;
    cs = 1'b0;
  endtask

  task automatic wait_irq(input int max, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (done_irq) begin seen = 1'b1; break; end
    end
  endtask

  task automatic wait_valid(input int max, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (mem_valid) begin seen = 1'b1; break; end
    end
  endtask

  // fill source, build expected bus sequence, program and start
  task automatic start_copy(input logic [31:0] src, input logic [31:0] dst, input int len);
    obs_q.delete();
    exp_q.delete();
    for (int i = 0; i < len; i++) begin
      mem[src + 32'(4 * i)] = pat(src + 32'(4 * i));
      exp_q.push_back('{4'h0, src + 32'(4 * i), pat(src + 32'(4 * i))});
      exp_q.push_back('{4'hf, dst + 32'(4 * i), pat(src + 32'(4 * i))});
    end
    cfg_write(ADDR_SRC, src);
    cfg_write(ADDR_DST, dst);
    cfg_write(ADDR_LEN, 32'(len));
    cfg_write(ADDR_CTRL, 32'h1);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    do_reset();
    total++; if (mem_valid !== 1'b0 || mem_wstrb !== 4'h0 || mem_addr !== 32'h0) begin bad++;
      $display("FAIL reset_bus valid=%b wstrb=%h addr=%h exp 0", mem_valid, mem_wstrb, mem_addr); end
    total++; if (done_irq !== 1'b0) begin bad++; $display("FAIL reset_irq got=%b exp=0", done_irq); end
    cfg_read(ADDR_STATUS, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL reset_status got=%h exp=0", d); end
    cfg_read(ADDR_SRC, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL reset_src got=%h exp=0", d); end
    cfg_read(ADDR_REMAINING, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL reset_remaining got=%h exp=0", d); end
  endtask

  task automatic test_regs();
    logic [31:0] d;
    cfg_read(ADDR_NAME0, d);
    total++; if (d !== 32'h646d615f) begin bad++; $display("FAIL name0 got=%h exp=646d615f", d); end
    cfg_read(ADDR_NAME1, d);
    total++; if (d !== 32'h636f7079) begin bad++; $display("FAIL name1 got=%h exp=636f7079", d); end
    cfg_read(ADDR_VERSION, d);
    total++; if (d !== 32'h1) begin bad++; $display("FAIL version got=%h exp=1", d); end
    cfg_write(ADDR_SRC, 32'h1234_5677);
    cfg_read(ADDR_SRC, d);
    total++; if (d !== 32'h1234_5674) begin bad++; $display("FAIL src_align got=%h exp=12345674", d); end
    cfg_write(ADDR_LEN, 32'habcd_1234);
    cfg_read(ADDR_LEN, d);
    total++; if (d !== 32'h0000_1234) begin bad++; $display("FAIL len_width got=%h exp=00001234", d); end
    cfg_write(8'h20, 32'hffff_ffff);
    cfg_read(8'h20, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL unmapped got=%h exp=0", d); end
    @(negedge clk);
    cs = 1'b0; address = ADDR_NAME0;
    #1;
    total++; if (read_data !== 32'h0 || ready !== 1'b0) begin bad++;
      $display("FAIL cs_low rdata=%h ready=%b exp 0/0", read_data, ready); end
    cs = 1'b1;
    #1;
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL ready_cs got=%b exp=1", ready); end
    cs = 1'b0;
  endtask

  task automatic test_basic_copy();
    logic [31:0] d;
    bit seen;
    int irq0, gap0;
    rsp_rand = 1'b0; rsp_fixed_lat = 1;
    irq0 = irq_cnt; gap0 = gap_viol;
    start_copy(32'h4000_0000, 32'h4000_1000, 4);
    wait_irq(500, seen);
    total++; if (!seen) begin bad++; $display("FAIL basic_irq_timeout got=none exp=pulse"); end
    repeat (4) @(negedge clk);
    total++; if (obs_q.size() !== exp_q.size()) begin bad++;
      $display("FAIL basic_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      total++; if (obs_q[i] !== exp_q[i]) begin bad++;
        $display("FAIL basic_txn%0d got=%h exp=%h", i, obs_q[i], exp_q[i]); end
    end
    for (int i = 0; i < 4; i++) begin
      total++; if (mem[32'h4000_1000 + 32'(4 * i)] !== pat(32'h4000_0000 + 32'(4 * i))) begin bad++;
        $display("FAIL basic_data%0d got=%h exp=%h", i, mem[32'h4000_1000 + 32'(4 * i)],
                 pat(32'h4000_0000 + 32'(4 * i))); end
    end
    cfg_read(ADDR_STATUS, d);
    total++; if (d !== 32'h2) begin bad++; $display("FAIL basic_status got=%h exp=2", d); end
    total++; if (irq_cnt - irq0 !== 1 || irq_wide !== 0) begin bad++;
      $display("FAIL basic_irq_pulses got=%0d wide=%0d exp=1/0", irq_cnt - irq0, irq_wide); end
    total++; if (gap_viol - gap0 !== 0) begin bad++;
      $display("FAIL basic_gap got=%0d exp=0", gap_viol - gap0); end
  endtask

  task automatic test_len_zero();
    logic [31:0] d;
    int v0;
    v0 = valid_cycles;
    cfg_write(ADDR_LEN, 32'h0);
    cfg_write(ADDR_CTRL, 32'h1);
    total++; if (done_irq !== 1'b1) begin bad++; $display("FAIL len0_irq got=%b exp=1", done_irq); end
    cfg_read(ADDR_STATUS, d);
    total++; if (d !== 32'h2) begin bad++; $display("FAIL len0_status got=%h exp=2", d); end
    repeat (10) @(negedge clk);
    total++; if (valid_cycles - v0 !== 0) begin bad++;
      $display("FAIL len0_bus got=%0d valid cycles exp=0", valid_cycles - v0); end
  endtask

  task automatic test_random_latency();
    logic [31:0] d;
    bit seen;
    int u0, g0;
    rsp_rand = 1'b1;
    u0 = unstable; g0 = gap_viol;
    start_copy(32'h2000_0100, 32'h2000_8000, 6);
    wait_valid(50, seen);
    cfg_write(ADDR_SRC, 32'h0);
    cfg_write(ADDR_CTRL, 32'h1);
    wait_irq(1000, seen);
    total++; if (!seen) begin bad++; $display("FAIL rand_irq_timeout got=none exp=pulse"); end
    repeat (4) @(negedge clk);
    total++; if (obs_q.size() !== exp_q.size()) begin bad++;
      $display("FAIL rand_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      total++; if (obs_q[i] !== exp_q[i]) begin bad++;
        $display("FAIL rand_txn%0d got=%h exp=%h", i, obs_q[i], exp_q[i]); end
    end
    total++; if (unstable - u0 !== 0 || gap_viol - g0 !== 0) begin bad++;
      $display("FAIL rand_protocol unstable=%0d gap=%0d exp=0/0", unstable - u0, gap_viol - g0); end
    cfg_read(ADDR_SRC, d);
    total++; if (d !== 32'h2000_0100) begin bad++; $display("FAIL busy_src_write got=%h exp=20000100", d); end
    rsp_rand = 1'b0;
  endtask

  task automatic test_abort();
    logic [31:0] d;
    bit seen;
    int irq0;
    rsp_fixed_lat = 3;
    cfg_write(ADDR_CTRL, 32'h2);
    cfg_read(ADDR_STATUS, d);
    total++; if (d !== 32'h2) begin bad++; $display("FAIL idle_abort got=%h exp=2", d); end
    irq0 = irq_cnt;
    start_copy(32'h3000_0000, 32'h3000_4000, 8);
    exp_q.delete();
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back('{4'h0, 32'h3000_0000 + 32'(4 * i), pat(32'h3000_0000 + 32'(4 * i))});
      exp_q.push_back('{4'hf, 32'h3000_4000 + 32'(4 * i), pat(32'h3000_0000 + 32'(4 * i))});
    end
    exp_q.push_back('{4'h0, 32'h3000_0008, pat(32'h3000_0008)});
    seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (mem_valid && mem_wstrb == 4'h0 && mem_addr == 32'h3000_0008) begin seen = 1'b1; break; end
    end
    total++; if (!seen) begin bad++; $display("FAIL abort_rd2_wait got=none exp=read of word 2"); end
    cfg_write(ADDR_CTRL, 32'h3);
    wait_irq(200, seen);
    repeat (6) @(negedge clk);
    total++; if (obs_q.size() !== exp_q.size()) begin bad++;
      $display("FAIL abort_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      total++; if (obs_q[i] !== exp_q[i]) begin bad++;
        $display("FAIL abort_txn%0d got=%h exp=%h", i, obs_q[i], exp_q[i]); end
    end
    cfg_read(ADDR_STATUS, d);
    total++; if (d !== 32'h4) begin bad++; $display("FAIL abort_status got=%h exp=4", d); end
    cfg_read(ADDR_REMAINING, d);
    total++; if (d !== 32'd6) begin bad++; $display("FAIL abort_remaining got=%0d exp=6", d); end
    total++; if (irq_cnt - irq0 !== 1) begin bad++; $display("FAIL abort_irq got=%0d exp=1", irq_cnt - irq0); end
    total++; if (mem.exists(32'h3000_4008)) begin bad++; $display("FAIL abort_extra_write got=present exp=absent"); end
  endtask

  task automatic test_wrap();
    bit seen;
    rsp_fixed_lat = 2;
    start_copy(32'hffff_fff8, 32'h5000_0000, 3);
    wait_irq(300, seen);
    repeat (4) @(negedge clk);
    total++; if (obs_q.size() !== 6) begin bad++; $display("FAIL wrap_count got=%0d exp=6", obs_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      total++; if (obs_q[i] !== exp_q[i]) begin bad++;
        $display("FAIL wrap_txn%0d got=%h exp=%h", i, obs_q[i], exp_q[i]); end
    end
    total++; if (obs_q.size() > 4 && obs_q[4].addr !== 32'h0) begin bad++;
      $display("FAIL wrap_addr got=%h exp=00000000", obs_q[4].addr); end
  endtask

  task automatic test_timeout();
    logic [31:0] d;
    bit seen;
    int n, irq0;
    rsp_en = 1'b0;
    irq0 = irq_cnt;
    start_copy(32'h6000_0000, 32'h6000_1000, 2);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      if (!mem_valid) break;
      n++;
      @(negedge clk);
    end
    total++; if (n !== 16) begin bad++; $display("FAIL timeout_valid_cycles got=%0d exp=16", n); end
    repeat (3) @(negedge clk);
    cfg_read(ADDR_STATUS, d);
    total++; if (d !== 32'h8) begin bad++; $display("FAIL timeout_status got=%h exp=8", d); end
    total++; if (irq_cnt - irq0 !== 1) begin bad++; $display("FAIL timeout_irq got=%0d exp=1", irq_cnt - irq0); end
    rsp_en = 1'b1;
    seen = 1'b1;
  endtask

  task automatic test_reset_mid_copy();
    logic [31:0] d;
    bit seen;
    rsp_fixed_lat = 5;
    start_copy(32'h7000_0000, 32'h7000_1000, 4);
    wait_valid(50, seen);
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    total++; if (mem_valid !== 1'b0 || done_irq !== 1'b0) begin bad++;
      $display("FAIL rst_mid_bus valid=%b irq=%b exp 0/0", mem_valid, done_irq); end
    cfg_read(ADDR_STATUS, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL rst_mid_status got=%h exp=0", d); end
    cfg_read(ADDR_SRC, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL rst_mid_src got=%h exp=0", d); end
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_regs();
    test_basic_copy();
    test_len_zero();
    test_random_latency();
    test_abort();
    test_wrap();
`ifdef MEM_COPY_DMA_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_mid_copy();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_time_limit got=expired exp=finish");
    $fatal(1, "time limit");
  end

endmodule
